// File: rtl/fru_bitstream_serializer.sv
// fru_bitstream_serializer: double-buffered framer that shifts CFG_WIDTH configuration bits out MSB-first.
// Define FRU_SERIALIZER_CRC_EN to append a CRC-8 (poly 0x07, init 0x00) trailer to every frame.
module fru_bitstream_serializer #(
  parameter int WORD_WIDTH = 32,
  parameter int CFG_WIDTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StartFrame,
  input  logic                  Abort,
  input  logic [WORD_WIDTH-1:0] WordIn,
  input  logic                  WordValid,
  output logic                  WordReady,
  output logic                  BitStreamSerialOut,
  output logic                  BitStreamValid,
  output logic                  Busy,
  output logic                  FrameDone,
  output logic                  Underrun
);
  localparam int NWORDS = (CFG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int REM = CFG_WIDTH - (NWORDS - 1) * WORD_WIDTH;
`ifdef FRU_SERIALIZER_CRC_EN
  localparam int TOTAL = CFG_WIDTH + 8;
  localparam int SRW = WORD_WIDTH < 8 ? 8 : WORD_WIDTH;
`else
  localparam int TOTAL = CFG_WIDTH;
  localparam int SRW = WORD_WIDTH;
`endif
  localparam int BW = $clog2(TOTAL + 1);
  localparam int WW = $clog2(NWORDS + 1);
  localparam int CW = $clog2(SRW + 1);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, FINISH = 2'd2;
  logic [1:0] state_q, state_d;
  logic [WORD_WIDTH-1:0] h_q, h_d;
  logic h_full_q, h_full_d, h_last_q, h_last_d;
  logic [SRW-1:0] sr_q, sr_d;
  logic [CW-1:0] sr_cnt_q, sr_cnt_d;
  logic valid_q, valid_d;
  logic [BW-1:0] bits_q, bits_d;
  logic [WW-1:0] words_q, words_d;
  logic shift, xfer, hs, done;
`ifdef FRU_SERIALIZER_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic last_frame_bit;
`endif
  assign Busy = state_q == FETCH;
  assign FrameDone = state_q == FINISH;
  assign BitStreamValid = valid_q;
  assign BitStreamSerialOut = sr_q[SRW-1];
  assign Underrun = Busy && !valid_q && bits_q != '0;
  always_comb begin
    shift = valid_q;
    done = shift && bits_q == BW'(TOTAL - 1);
    // H drains into SR when SR is empty or is shipping its final bit this edge
    xfer = h_full_q && sr_cnt_q <= CW'(1);
    WordReady = Busy && (!h_full_q || xfer) && words_q < WW'(NWORDS);
    hs = WordReady && WordValid && !Abort;
    state_d = state_q == IDLE ? (StartFrame ? FETCH : IDLE) :
              state_q == FETCH ? (Abort ? IDLE : done ? FINISH : FETCH) : IDLE;
    sr_d = shift ? sr_q << 1 : sr_q;
    sr_cnt_d = shift ? sr_cnt_q - CW'(1) : sr_cnt_q;
    if (xfer) begin
      sr_d = SRW'(h_q) << (SRW - WORD_WIDTH);
      sr_cnt_d = h_last_q ? CW'(REM) : CW'(WORD_WIDTH);
    end
`ifdef FRU_SERIALIZER_CRC_EN
    last_frame_bit = shift && bits_q == BW'(CFG_WIDTH - 1);
    crc_d = crc_q;
    if (shift && bits_q < BW'(CFG_WIDTH))
      crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ sr_q[SRW-1]) ? 8'h07 : 8'h00);
    if (last_frame_bit) begin
      sr_d = SRW'(crc_d) << (SRW - 8);
      sr_cnt_d = CW'(8);
    end
`endif
    h_full_d = (h_full_q && !xfer) || hs;
    h_last_d = hs ? words_q == WW'(NWORDS - 1) : h_last_q;
    h_d = !hs ? h_q : words_q == WW'(NWORDS - 1) ? WordIn << (WORD_WIDTH - REM) : WordIn;
    bits_d = bits_q + BW'(shift);
    words_d = words_q + WW'(hs);
    if (state_q != FETCH || Abort) begin
      h_d = '0;
      h_full_d = 1'b0;
      h_last_d = 1'b0;
      sr_d = '0;
      sr_cnt_d = '0;
      bits_d = '0;
      words_d = '0;
`ifdef FRU_SERIALIZER_CRC_EN
      crc_d = '0;
`endif
    end
    valid_d = sr_cnt_d != '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      h_q <= '0;
      h_full_q <= 1'b0;
      h_last_q <= 1'b0;
      sr_q <= '0;
      sr_cnt_q <= '0;
      valid_q <= 1'b0;
      bits_q <= '0;
      words_q <= '0;
`ifdef FRU_SERIALIZER_CRC_EN
      crc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      h_full_q <= h_full_d;
      h_last_q <= h_last_d;
      sr_q <= sr_d;
      sr_cnt_q <= sr_cnt_d;
      valid_q <= valid_d;
      bits_q <= bits_d;
      words_q <= words_d;
`ifdef FRU_SERIALIZER_CRC_EN
      crc_q <= crc_d;
`endif
    end
  end
endmodule

// File: doc/fru_bitstream_serializer.md
Name: fru_bitstream_serializer

Overview:
- Transmit end of the FRU configuration bitstream link.
- Accepts parallel configuration words from the patch-loader host over a valid/ready handshake and frames exactly CFG_WIDTH bits.
- Shifts the frame out MSB-first on BitStreamSerialOut/BitStreamValid; these feed the FRU bitstream deserializer input.
- Double-buffered so a host that keeps up sees no gaps in the serial stream.

Parameters:
- WORD_WIDTH, 32, width of host parallel words.
- CFG_WIDTH, 1024, number of configuration bits per frame; must be >= 1.
- NWORDS (localparam), ceil(CFG_WIDTH/WORD_WIDTH), words per frame.
- REM (localparam), CFG_WIDTH - (NWORDS-1)*WORD_WIDTH, valid bits in the final word (1..WORD_WIDTH).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- StartFrame  in  1  begin a frame; sampled only in IDLE.
- Abort  in  1  cancel the current frame.
- WordIn  in  WORD_WIDTH  configuration word.
- WordValid  in  1  host word valid.
- WordReady  out  1  block can accept WordIn.
- BitStreamSerialOut  out  1  serial data bit.
- BitStreamValid  out  1  serial bit valid.
- Busy  out  1  frame in progress.
- FrameDone  out  1  one-cycle pulse at frame completion.
- Underrun  out  1  high in any mid-frame cycle where the serial stream stalls for lack of data.

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; holding register H and shift register SR cleared and marked empty; all counters 0.
  - All outputs 0.
- FSM states:
  - IDLE: Busy=0, WordReady=0. StartFrame=1 -> FETCH next edge. Abort is ignored in IDLE.
  - FETCH: Busy=1. WordReady = H empty && words_accepted < NWORDS.
    - Handshake (WordValid && WordReady at an edge) writes WordIn into H and increments words_accepted.
    - Exits to FINISH when bits_sent reaches CFG_WIDTH (or the CRC trailer has been sent, see Optional Feature).
  - FINISH: FrameDone=1 for exactly one cycle; Busy=0 in this cycle; next state IDLE.
- Datapath:
  - H -> SR transfer occurs at any edge where H is full and SR is empty or sending its last bit.
  - This transfer frees H in the same edge, so a new handshake can be accepted at that edge (H loaded with new word while old moves to SR).
  - Full words load all WORD_WIDTH bits.
  - The final (NWORDS-th) word loads only WordIn[REM-1:0], left-aligned so bit REM-1 is sent first; the upper bits are discarded.
  - BitStreamSerialOut = SR MSB; BitStreamValid = SR nonempty. Both are registered outputs.
- Latency:
  - First handshake at edge T -> SR loaded at T+1 -> first valid bit visible in the cycle after T+1.
  - Thereafter one bit per cycle with no gaps while the host supplies each word before SR drains.
- Underrun: SR empty, bits_sent < CFG_WIDTH, state FETCH, and at least one bit already sent -> BitStreamValid=0 and Underrun=1. Shifting resumes with no bit lost or duplicated.
- Abort=1 in FETCH:
  - Next edge -> IDLE; H and SR cleared; counters cleared.
  - BitStreamValid and WordReady drop that edge. No FrameDone.
  - A handshake in the same cycle as Abort is discarded.
- StartFrame while Busy: ignored.
- StartFrame in the FINISH cycle: ignored; a new frame needs StartFrame in IDLE.
- Counters sized $clog2(CFG_WIDTH+1) and $clog2(NWORDS+1); no wrap-around within a frame.
- WordValid outside FETCH: ignored, since WordReady=0.

Optional Feature:
- Macro: FRU_SERIALIZER_CRC_EN.
- Defined:
  - CRC-8 (poly 0x07, init 0x00) computed over the CFG_WIDTH frame bits in transmission order.
  - Appended as 8 extra bits, MSB first, immediately after the last frame bit, with BitStreamValid=1. No gap is allowed.
  - FINISH is entered after the 8th CRC bit; a frame is CFG_WIDTH+8 serial bits.
  - Abort during CRC bits behaves as in FETCH.
- Undefined: no CRC logic; a frame is exactly CFG_WIDTH bits.

Test Plan:
- Back-to-back frame (WORD_WIDTH=32, CFG_WIDTH=70, CRC off):
  - Stimulus: StartFrame, then words 0xA5A5A5A5, 0x0F0F0F0F, 0xFFFFFF2B, host always valid.
  - Response: 70 contiguous valid bits = A5A5A5A5, 0F0F0F0F, then 6'b101011 MSB-first.
  - FrameDone pulses one cycle after the last bit; WordReady never high after the 3rd handshake.
- Underrun:
  - Stimulus: same frame, second word delayed 5 cycles after SR empties.
  - Response: BitStreamValid=0 and Underrun=1 for 5 cycles; the bit sequence is identical to the back-to-back case.
- Abort:
  - Stimulus: Abort asserted after 40 bits sent.
  - Response: next cycle BitStreamValid=0, Busy=0, no FrameDone. A following StartFrame sends a fresh 70-bit frame from its first word.
- Reset mid-frame:
  - Stimulus: rst low asynchronously mid-bit.
  - Response: all outputs 0 immediately, without waiting for a clock edge; state IDLE after release.
- StartFrame while Busy:
  - Stimulus: StartFrame pulsed mid-frame.
  - Response: no effect on bit count or FrameDone timing.
- CRC (FRU_SERIALIZER_CRC_EN):
  - Stimulus: all-zero frame except the final frame bit = 1.
  - Response: trailer 0x07 sent MSB-first. An all-zero frame gives trailer 0x00. 78 valid bits total in each case.
